sum_tree_pipe: RTL and testbench
================================

// Module: sum_tree_pipe
// PURPOSE
//  Parametrised, pipelined multi-operand adder for systolic-array partial-sum reduction.
//  Reduces NUM_IN packed operands of DATA_W bits to one full-precision sum via a registered
//  binary tree. Valid/ready handshake with backpressure. Optional per-group accumulation.
//  Successor to the combinational `sum`: parametrised width, operand count and signedness.
// PARAMETERS
//  NUM_IN   4   operand count, >=1; non-power-of-2 counts padded with zero operands
//  DATA_W   3   bits per operand
//  SIGNED   0   1: operands and results two's complement; 0: unsigned
//  ACC_W    16  accumulator width; used only with SUM_TREE_ACC_EN
//  localparam LEVELS  = (NUM_IN<=1) ? 1 : $clog2(NUM_IN)
//  localparam SUM_W   = DATA_W + $clog2(NUM_IN)  (1-operand case: DATA_W)
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              asynchronous, active-low reset (0 = reset)
//  in_data    in   NUM_IN*DATA_W  operand k at [k*DATA_W +: DATA_W]
//  in_valid   in   1              operand vector valid
//  in_ready   out  1              block accepts in_data this cycle
//  in_first   in   1              first beat of accumulation group (ACC_EN only)
//  in_last    in   1              last beat of accumulation group (ACC_EN only)
//  out_data   out  SUM_W or ACC_W sum (ACC_W wide when SUM_TREE_ACC_EN defined)
//  out_valid  out  1              out_data valid
//  out_ready  in   1              downstream accepts out_data
// BEHAVIOUR
//  - Reset (rst=0, async): all stage valids, out_valid, out_data, accumulator -> 0.
//    In-flight data is discarded. in_ready = 1 whenever rst=1 and not stalled.
//  - Stall = out_valid & ~out_ready. Entire pipeline holds (global enable = ~stall).
//    in_ready = ~stall (combinational). Transfer in on in_valid&in_ready; out on out_valid&out_ready.
//  - Tree: level L adds operand pairs, one register per level; odd leftover passes through
//    registered. Each level widens by 1 bit; sign-extend if SIGNED, zero-extend otherwise.
//    Never overflows: output exact over all inputs.
//  - Latency (no stall): LEVELS cycles from accepted input to out_valid. Throughput 1/cycle.
//  - Bubbles (in_valid=0) propagate as invalid stages; data regs may hold stale values.
//  - out_data stable while out_valid & ~out_ready.
// CONFIGURATION
//  Macro SUM_TREE_ACC_EN (defined in config.v).
//  Undefined: every accepted beat yields one output; in_first/in_last ignored.
//  Defined: one extra accumulator stage (latency LEVELS+1). Tree sum extended to ACC_W
//    (per SIGNED), acc <= in_first ? sum : acc+sum, modulo 2^ACC_W (wrap, no saturation).
//    out_valid asserts only for the beat tagged in_last; out_data = final group total.
//    in_first & in_last same beat: single-beat group, out = that sum. Beat without
//    preceding in_first accumulates onto existing acc. first/last travel with data.
// STRUCTURE
//  - config.v: SUM_TREE_ACC_EN, shared CLOG2 helper macro, default widths.
//  - Sub-module sum_tree_level: one level, parameters IN_CNT, IN_W, SIGNED; pairwise
//    adders + data/valid/first/last registers with enable. Top uses generate over LEVELS.
//  - Accumulator stage and handshake logic in top.
// TESTING
//  1 defaults, in_data=12'b010_010_000_010, valid 1 beat -> after 2 cycles out_data=6, out_valid 1 cycle.
//  2 all-max 3'b111 x4 -> 28 (5'b11100); SIGNED=1 all 3'b100 -> -16 (5'b10000).
//  3 back-to-back 1..4 per beat, out_ready low 3 cycles mid-stream -> in_ready low, no
//    loss/dup, outputs in order, out_data stable during stall.
//  4 NUM_IN=5, DATA_W=8, all 255 -> 1275 after 3 cycles (odd-operand padding).
//  5 SUM_TREE_ACC_EN: 3 beats sum 6 (first,-,last) -> single out 18; first&last beat -> its own sum.
//  6 rst=0 mid-stream with 2 beats in flight -> out_valid/out_data 0 immediately; no stale output after release.

Source files
------------

// File: rtl/sum_tree_pipe_pkg.sv
// Shared defaults and elaboration helpers for the sum_tree_pipe reduction tree.
package sum_tree_pipe_pkg;

  localparam int DEF_NUM_IN = 4;
  localparam int DEF_DATA_W = 3;
  localparam int DEF_ACC_W  = 16;

  // Operand count entering tree level l (ceil(n / 2^l)).
  function automatic int lvl_cnt(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction

  function automatic int tree_levels(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sum_tree_pipe_level.sv
// One registered level of the reduction tree: pairwise adds, odd leftover passes through.
module sum_tree_level #(
  parameter int IN_CNT   = 2,
  parameter int IN_W     = 3,
  parameter bit SIGNED   = 1'b0,
  localparam int OUT_CNT = (IN_CNT + 1) / 2,
  localparam int OUT_W   = IN_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     vld_in,
  input  logic                     first_in,
  input  logic                     last_in,
  input  logic [IN_CNT*IN_W-1:0]   data_in,
  output logic                     vld_p0,
  output logic                     first_p0,
  output logic                     last_p0,
  output logic [OUT_CNT*OUT_W-1:0] sum_p0
);

  function automatic logic [OUT_W-1:0] widen(input logic [IN_W-1:0] x);
    logic signed [IN_W-1:0] xs;
    xs = x;
    if (SIGNED) return OUT_W'(xs);
    else        return OUT_W'(x);
  endfunction

  logic [OUT_CNT*OUT_W-1:0] sum_c;

  for (genvar j = 0; j < OUT_CNT; j++) begin : g_pair
    logic [OUT_W-1:0] a, b;
    assign a = widen(data_in[2*j*IN_W +: IN_W]);
    if (2*j + 1 < IN_CNT) begin : g_b
      assign b = widen(data_in[(2*j+1)*IN_W +: IN_W]);
    end else begin : g_pad
      assign b = '0;
    end
    assign sum_c[j*OUT_W +: OUT_W] = a + b;
  end

  // ---- stage register: data is not reset, stale values are masked by vld_p0 ----
  always_ff @(posedge clk) begin
    if (en) sum_p0 <= sum_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
    end else if (en) begin
      vld_p0   <= vld_in;
      first_p0 <= first_in;
      last_p0  <= last_in;
    end
  end

endmodule

// File: rtl/sum_tree_pipe.sv
// Pipelined multi-operand adder tree with valid/ready backpressure.
// Define SUM_TREE_ACC_EN to add a per-group accumulator stage (ACC_W-wide output).
module sum_tree_pipe
  import sum_tree_pipe_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int DATA_W  = DEF_DATA_W,
  parameter bit SIGNED  = 1'b0,
  parameter int ACC_W   = DEF_ACC_W,
  localparam int LEVELS = tree_levels(NUM_IN),
  localparam int SUM_W  = (NUM_IN <= 1) ? DATA_W : DATA_W + $clog2(NUM_IN),
`ifdef SUM_TREE_ACC_EN
  localparam int OUT_W  = ACC_W
`else
  localparam int OUT_W  = SUM_W
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic             en;
  logic             tree_vld, tree_first, tree_last;
  logic [SUM_W-1:0] tree_sum;

  // The whole pipeline freezes while the output is held by the consumer.
  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int ICNT = lvl_cnt(NUM_IN, l);
    localparam int IW   = DATA_W + l;
    localparam int OCNT = (ICNT + 1) / 2;
    localparam int OW   = IW + 1;

    logic [ICNT*IW-1:0] din;
    logic               vin, fin, lin;
    logic [OCNT*OW-1:0] dout;
    logic               vout, fout, lout;

    if (l == 0) begin : g_src
      assign din = in_data;
      assign vin = in_valid;
      assign fin = in_first;
      assign lin = in_last;
    end else begin : g_src
      assign din = g_lvl[l-1].dout;
      assign vin = g_lvl[l-1].vout;
      assign fin = g_lvl[l-1].fout;
      assign lin = g_lvl[l-1].lout;
    end

    sum_tree_level #(
      .IN_CNT (ICNT),
      .IN_W   (IW),
      .SIGNED (SIGNED)
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .vld_in   (vin),
      .first_in (fin),
      .last_in  (lin),
      .data_in  (din),
      .vld_p0   (vout),
      .first_p0 (fout),
      .last_p0  (lout),
      .sum_p0   (dout)
    );
  end

  assign tree_sum   = g_lvl[LEVELS-1].dout[SUM_W-1:0];
  assign tree_vld   = g_lvl[LEVELS-1].vout;
  assign tree_first = g_lvl[LEVELS-1].fout;
  assign tree_last  = g_lvl[LEVELS-1].lout;

`ifdef SUM_TREE_ACC_EN
  logic [OUT_W-1:0] acc_p1;
  logic             vld_p1;
  logic [OUT_W-1:0] sum_ext;

  function automatic logic [OUT_W-1:0] to_acc(input logic [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] ss;
    ss = s;
    if (SIGNED) return OUT_W'(ss);
    else        return OUT_W'(s);
  endfunction

  assign sum_ext = to_acc(tree_sum);

  // ---- accumulator stage: wraps modulo 2^ACC_W, emits only on group end ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (en) begin
      if (tree_vld) acc_p1 <= tree_first ? sum_ext : acc_p1 + sum_ext;
      vld_p1 <= tree_vld & tree_last;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = vld_p1 ? acc_p1 : '0;
`else
  logic unused_ctl;
  assign unused_ctl = tree_first ^ tree_last;
  assign out_valid  = tree_vld;
  assign out_data   = tree_vld ? tree_sum : '0;
`endif

endmodule

// File: tb/tb_sum_tree_pipe.sv
// Directed bench for sum_tree_pipe: default, signed and 5-operand instances share controls.
module tb_sum_tree_pipe;

`ifdef SUM_TREE_ACC_EN
  localparam int W_D = 16;
  localparam int W_N = 16;
  localparam int LAT_ADD = 1;
  localparam logic [31:0] EXP_NEG16 = 32'd65520;
  localparam logic [31:0] EXP_NEG1  = 32'd65535;
`else
  localparam int W_D = 5;
  localparam int W_N = 11;
  localparam int LAT_ADD = 0;
  localparam logic [31:0] EXP_NEG16 = 32'd16;
  localparam logic [31:0] EXP_NEG1  = 32'd31;
`endif
  localparam int LAT_D = 2 + LAT_ADD;
  localparam int LAT_N = 3 + LAT_ADD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b1, in_last = 1'b1, out_ready = 1'b1;
  logic [11:0] d_in = '0, s_in = '0;
  logic [39:0] n_in = '0;
  logic d_rdy, s_rdy, n_rdy, d_ov, s_ov, n_ov;
  logic [W_D-1:0] d_od, s_od;
  logic [W_N-1:0] n_od;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sum_tree_pipe u_def (
    .clk(clk), .rst(rst), .in_data(d_in), .in_valid(in_valid), .in_ready(d_rdy),
    .in_first(in_first), .in_last(in_last), .out_data(d_od), .out_valid(d_ov), .out_ready(out_ready)
  );

  sum_tree_pipe #(.SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .in_data(s_in), .in_valid(in_valid), .in_ready(s_rdy),
    .in_first(in_first), .in_last(in_last), .out_data(s_od), .out_valid(s_ov), .out_ready(out_ready)
  );

  sum_tree_pipe #(.NUM_IN(5), .DATA_W(8)) u_n5 (
    .clk(clk), .rst(rst), .in_data(n_in), .in_valid(in_valid), .in_ready(n_rdy),
    .in_first(in_first), .in_last(in_last), .out_data(n_od), .out_valid(n_ov), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Sends one beat to all three instances and records first-valid latency, value and valid count.
  task automatic send_watch(input logic [11:0] dd, input logic [11:0] ds, input logic [39:0] dn,
                            output int ld, output int ls, output int ln,
                            output logic [31:0] vd, output logic [31:0] vs, output logic [31:0] vn,
                            output int cd, output int cs, output int cn);
    ld = 0; ls = 0; ln = 0; cd = 0; cs = 0; cn = 0;
    vd = '0; vs = '0; vn = '0;
    out_ready = 1'b1;
    d_in = dd; s_in = ds; n_in = dn;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (d_ov) begin cd++; if (ld == 0) begin ld = k; vd = 32'(d_od); end end
      if (s_ov) begin cs++; if (ls == 0) begin ls = k; vs = 32'(s_od); end end
      if (n_ov) begin cn++; if (ln == 0) begin ln = k; vn = 32'(n_od); end end
      step();
    end
  endtask

  int ld, ls, ln, cd, cs, cn;
  logic [31:0] vd, vs, vn;
  int sent, got, extra;
  logic [31:0] held;
  logic held_v;

  initial begin
    // reset state
    step(); step();
    chk("rst_ovalid", 32'(d_ov), 0);
    chk("rst_odata", 32'(d_od), 0);
    #2 rst = 1'b1;
    step();
    chk("rst_inready", 32'(d_rdy), 1);

    // 2,0,2,2 -> 6 on both 3-bit instances
    send_watch(12'b010_010_000_010, 12'b010_010_000_010, 40'd0, ld, ls, ln, vd, vs, vn, cd, cs, cn);
    chk("t1_lat", 32'(ld), 32'(LAT_D));
    chk("t1_data", vd, 6);
    chk("t1_once", 32'(cd), 1);
    chk("t1_sgn", vs, 6);

    // all-max operands
    send_watch(12'hFFF, 12'b100_100_100_100, {5{8'hFF}}, ld, ls, ln, vd, vs, vn, cd, cs, cn);
    chk("t2_max", vd, 28);
    chk("t2_neg16", vs, EXP_NEG16);
    chk("t2_n5_lat", 32'(ln), 32'(LAT_N));
    chk("t2_n5_data", vn, 1275);
    chk("t2_n5_once", 32'(cn), 1);

    // mixed: ops 3,7,4,1 (signed 3,-1,-4,1); n5 ops 1..5
    send_watch(12'b001_100_111_011, 12'b001_100_111_011, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
               ld, ls, ln, vd, vs, vn, cd, cs, cn);
    chk("t2_mix_u", vd, 15);
    chk("t2_mix_s", vs, EXP_NEG1);
    chk("t2_mix_n5", vn, 15);

    // streaming with a three-cycle output stall
    sent = 0; got = 0; held = '0; held_v = 1'b0;
    n_in = '0; s_in = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = (sent < 4);
      d_in      = {4{3'(sent + 1)}};
      #1;
      if (held_v) chk("t3_hold", 32'(d_od), held);
      if (d_ov && !out_ready) begin
        chk("t3_inrdy", 32'(d_rdy), 0);
        held = 32'(d_od);
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (d_ov && out_ready) begin
        chk("t3_order", 32'(d_od), 32'(4 * (got + 1)));
        got++;
      end
      if (in_valid && d_rdy) sent++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("t3_count", 32'(got), 4);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      if (d_ov) extra++;
      step();
    end
    chk("t3_nodup", 32'(extra), 0);

`ifdef SUM_TREE_ACC_EN
    // three-beat group of 6 each, then a single-beat group
    d_in = 12'b010_010_000_010;
    s_in = 12'b010_010_000_010;
    in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_first = (b == 0);
      in_last  = (b == 2);
      step();
    end
    in_valid = 1'b0; in_first = 1'b1; in_last = 1'b1;
    cd = 0; vd = '0; vs = '0;
    for (int k = 0; k < 8; k++) begin
      if (d_ov) begin cd++; vd = 32'(d_od); vs = 32'(s_od); end
      step();
    end
    chk("t5_count", 32'(cd), 1);
    chk("t5_total", vd, 18);
    chk("t5_total_s", vs, 18);
    send_watch(12'hFFF, 12'hFFF, 40'd0, ld, ls, ln, vd, vs, vn, cd, cs, cn);
    chk("t5_single", vd, 28);
    chk("t5_single_n", 32'(cd), 1);
`endif

    // reset with beats in flight
    d_in = 12'b010_010_000_010;
    in_valid = 1'b1;
    step();
    d_in = 12'hFFF;
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_ovalid", 32'(d_ov), 0);
    chk("t6_odata", 32'(d_od), 0);
    step();
    rst = 1'b1;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      if (d_ov || n_ov || s_ov) extra++;
      step();
    end
    chk("t6_nostale", 32'(extra), 0);

    send_watch(12'b010_010_000_010, 12'd0, 40'd0, ld, ls, ln, vd, vs, vn, cd, cs, cn);
    chk("t6_after", vd, 6);
    chk("t6_after_lat", 32'(ld), 32'(LAT_D));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
